cp0_exc_ctrl: RTL
=================

// Module: cp0_exc_ctrl
// PURPOSE
//  Parametrised coprocessor-0 exception/interrupt controller for the MIPS core.
//  Owns SR/Cause/EPC/PRId and arbitrates hardware interrupts against the
//  already-prioritised synchronous exception code supplied by the datapath.
//  Raises req, captures EPC/BD and services mtc0/mfc0/eret.
//  Sits beside GRF/DM; req gates their write enables and redirects PC.
// PARAMETERS
//  HW_INT_NUM   6             number of external interrupt lines, 1..6, mapped to IP[10+i]
//  PRID         32'h2024_0005 read-only value of register 15 (PRId)
//  HANDLER_PC   32'h0000_4180 value driven on Handler_Out
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high
//  en           in   1           mtc0 write strobe
//  CP0_Addr     in   5           register index for mtc0/mfc0
//  CP0_In       in   32          mtc0 write data
//  VPC          in   32          PC of the instruction being committed this cycle
//  BDIn         in   1           committed instruction is in a branch delay slot
//  Exception    in   5           ExcCode of committed instruction; 0 = none
//  HWInt        in   HW_INT_NUM  level-sensitive external interrupt lines
//  EXLClr       in   1           eret strobe
//  CP0_Out      out  32          mfc0 read data (combinational)
//  EPC_Out      out  32          current EPC
//  Handler_Out  out  32          HANDLER_PC constant
//  req          out  1           take exception/interrupt this cycle (combinational)
// BEHAVIOUR
//  Registers (clk rising edge; reset clears to 0):
//  - SR (12): IM[15:10] rw, EXL[1] rw, IE[0] rw; other bits read 0.
//  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; read-only via mtc0.
//  - EPC (14): rw, bits[1:0] forced 0 on every write.
//  - PRId (15): PRID; unimplemented indices read 0.
//  Interrupt: int_req = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL.
//  Exception: exc_req = (Exception != 0) & ~SR.EXL.
//  req = int_req | exc_req, same cycle (0-cycle latency).
//  - Interrupt wins over exception; ExcCode then = 0.
//  Cause.IP updated every cycle from registered HWInt.
//  - One-cycle lag from HWInt to IP; unused IP bits stay 0.
//  On req:
//  - SR.EXL <= 1.
//  - Cause.ExcCode <= 0 (interrupt) or Exception.
//  - Cause.BD <= BDIn.
//  - EPC <= (BDIn ? VPC-4 : VPC) & ~3.
//  - Any mtc0 in the same cycle is dropped.
//  mtc0 (en & ~req): writes the addressed register next edge; CP0_Out shows new value one cycle later.
//  eret (EXLClr): SR.EXL <= 0 next edge; req is 0 that cycle since EXL still 1.
//  mtc0 to SR and EXLClr in the same cycle: EXLClr wins for EXL, write applies to IM/IE.
//  EPC_Out reflects the registered EPC; mtc0 to EPC visible next cycle.
//  Reset mid-exception: all state cleared; req low in the reset cycle.
// CONFIGURATION
//  CP0_TIMER_EN defined:
//  - Count (9) increments by 1 every cycle, wraps 32'hFFFF_FFFF -> 0; mtc0 to Count overrides the increment.
//  - Compare (11) rw.
//  - When Count == Compare and Compare != 0, timer pending sets IP[15] (sticky).
//  - Write to Compare clears the pending bit; IP[15] masked by SR.IM[15] (IM[15:10] widens to IM[15:10]).
//  CP0_TIMER_EN undefined: regs 9/11 read 0, writes ignored, IP[15] = 0.
// TESTING
//  1. reset; mfc0 12/13/14/15 -> 0,0,0,PRID; req=0.
//  2. Exception=5'd4, VPC=32'h3008, BDIn=0 -> req=1 same cycle;
//     next cycle EPC=32'h3008, ExcCode=4, EXL=1.
//  3. BDIn=1, VPC=32'h3010, Exception=5'd12 -> EPC=32'h300C, Cause.BD=1.
//  4. mtc0 SR=32'h0000_0401, HWInt=6'b1 -> IP[10]=1 after 1 cycle, req=1 with ExcCode 0;
//     with Exception=4 simultaneously, ExcCode=0 still.
//  5. EXL=1, Exception=4 -> req=0; EXLClr -> EXL=0 next cycle, pending int then raises req.
//  6. CP0_TIMER_EN: Compare=10, SR=32'h0000_8001
//     -> req when Count hits 10 (+1 cycle); Compare write clears IP[15].

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception/interrupt controller.
// Holds SR/Cause/EPC/PRId, arbitrates interrupts against the datapath's
// exception code, raises req and services mtc0/mfc0/eret.
// Optional timer (Count/Compare driving IP[15]) is enabled by CP0_TIMER_EN.
module cp0_exc_ctrl #(
  parameter int          HW_INT_NUM = 6,
  parameter logic [31:0] PRID       = 32'h2024_0005,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4:0]            CP0_Addr,
  input  logic [31:0]           CP0_In,
  input  logic [31:0]           VPC,
  input  logic                  BDIn,
  input  logic [4:0]            Exception,
  input  logic [HW_INT_NUM-1:0] HWInt,
  input  logic                  EXLClr,
  output logic [31:0]           CP0_Out,
  output logic [31:0]           EPC_Out,
  output logic [31:0]           Handler_Out,
  output logic                  req
);

  localparam logic [4:0] A_COUNT = 5'd9;
  localparam logic [4:0] A_CMP   = 5'd11;
  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl, sr_ie;
  logic        cause_bd;
  logic [5:0]  ip_q, ip_nxt, ip_eff;
  logic [4:0]  exc_q;
  logic [31:0] epc_q, epc_nxt;
  logic        int_req, exc_req, wr;

  // Widen the external lines onto the 6-bit IP field; unused bits stay 0
  always_comb begin
    ip_nxt = '0;
    for (int i = 0; i < HW_INT_NUM; i++) ip_nxt[i] = HWInt[i];
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, cmp_q;
  logic        tmr_pend;

  // Free-running Count, writable Compare, sticky match flag cleared by a Compare write
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      cmp_q    <= '0;
      tmr_pend <= 1'b0;
    end else begin
      count_q <= (wr && CP0_Addr == A_COUNT) ? CP0_In : count_q + 32'd1;
      if (wr && CP0_Addr == A_CMP) begin
        cmp_q    <= CP0_In;
        tmr_pend <= 1'b0;
      end else if (count_q == cmp_q && cmp_q != 32'd0) begin
        tmr_pend <= 1'b1;
      end
    end
  end

  assign ip_eff = {ip_q[5] | tmr_pend, ip_q[4:0]};
`else
  assign ip_eff = ip_q;
`endif

  // Reset forces req low so a stale exception code cannot redirect the PC
  assign int_req = (|(ip_eff & sr_im)) & sr_ie & ~sr_exl & ~reset;
  assign exc_req = (Exception != 5'd0) & ~sr_exl & ~reset;
  assign req     = int_req | exc_req;
  assign wr      = en & ~req;
  assign epc_nxt = (BDIn ? VPC - 32'd4 : VPC) & ~32'd3;

  assign EPC_Out     = epc_q;
  assign Handler_Out = HANDLER_PC;

  // Architectural state: mtc0 first, then eret, then exception entry overrides
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im    <= '0;
      sr_exl   <= 1'b0;
      sr_ie    <= 1'b0;
      cause_bd <= 1'b0;
      ip_q     <= '0;
      exc_q    <= '0;
      epc_q    <= '0;
    end else begin
      ip_q <= ip_nxt;
      if (wr && CP0_Addr == A_SR) begin
        sr_im  <= CP0_In[15:10];
        sr_exl <= CP0_In[1];
        sr_ie  <= CP0_In[0];
      end
      if (wr && CP0_Addr == A_EPC) epc_q <= {CP0_In[31:2], 2'b00};
      if (EXLClr) sr_exl <= 1'b0;
      if (req) begin
        sr_exl   <= 1'b1;
        exc_q    <= int_req ? 5'd0 : Exception;
        cause_bd <= BDIn;
        epc_q    <= epc_nxt;
      end
    end
  end

  // mfc0 read mux
  always_comb begin
    CP0_Out = '0;
    case (CP0_Addr)
      A_SR:    CP0_Out = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
      A_CAUSE: CP0_Out = {cause_bd, 15'b0, ip_eff, 3'b0, exc_q, 2'b0};
      A_EPC:   CP0_Out = epc_q;
      A_PRID:  CP0_Out = PRID;
`ifdef CP0_TIMER_EN
      A_COUNT: CP0_Out = count_q;
      A_CMP:   CP0_Out = cmp_q;
`endif
      default: CP0_Out = '0;
    endcase
  end

endmodule
